// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift-subtract step per clock,
// N steps per division, with a single-cycle done pulse and held results.
module seq_divider #(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_zero_o
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_divisor;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_divZero;

    logic          w_accept;
    logic          w_lastStep;
    logic [N:0]    w_shifted;
    logic [N:0]    w_trial;
    logic          w_negative;
    logic [N-1:0]  w_quoNext;
    logic [N-1:0]  w_remNext;

    // A restored remainder always fits in N bits: the shifted value only
    // exceeds N bits when the trial subtraction is guaranteed to succeed.
    always_comb begin
        w_accept   = start_i && ((r_state == IDLE) || (r_state == DONE));
        w_lastStep = (r_count == CW'(N - 1));
        w_shifted  = {r_rem, r_quo[N-1]};
        w_trial    = w_shifted - {1'b0, r_divisor};
        w_negative = w_trial[N];
        w_quoNext  = {r_quo[N-2:0], ~w_negative};
        w_remNext  = w_negative ? w_shifted[N-1:0] : w_trial[N-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divZero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_quo     <= dividend_i;
                r_rem     <= '0;
                r_divisor <= divisor_i;
                r_count   <= '0;
                if (divisor_i == '0) begin
                    // Zero divisor skips the iterations entirely.
                    r_state     <= DONE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_quotient  <= '1;
                    r_remainder <= dividend_i;
                    r_divZero   <= 1'b1;
                end else begin
                    r_state <= CALC;
                    r_busy  <= 1'b1;
                end
            end else begin
                case (r_state)
                    CALC: begin
                        r_quo   <= w_quoNext;
                        r_rem   <= w_remNext;
                        r_count <= r_count + CW'(1);
                        if (w_lastStep) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_quotient  <= w_quoNext;
                            r_remainder <= w_remNext;
                            r_divZero   <= 1'b0;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    IDLE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;
    assign div_zero_o  = r_divZero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider (N=16): latency, results,
// divide-by-zero, ignored mid-calculation starts, back-to-back and async reset.
module tb_seq_divider;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         divZero;

    int assertCount = 0;
    int failCount   = 0;

    seq_divider #(.N(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .div_zero_o  (divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start from the current point (just after a rising
    // edge) and steps edges until done is seen. Optionally pulses a second
    // start mid-calculation and samples the held quotient at edge 8.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input bit midPulse, output int cycles,
                                 output bit busySeen, output logic [N-1:0] midQ);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        cycles   = 0;
        busySeen = 1'b0;
        midQ     = '0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) start = 1'b0;
            if (midPulse && cycles == 5) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 16'd3;
            end
            if (midPulse && cycles == 6) start = 1'b0;
            if (cycles == 8) midQ = quotient;
            if (busy) busySeen = 1'b1;
        end while (!done && cycles < 40);
    endtask

    task automatic stepCycles(input int n, output int donePulses);
        donePulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) donePulses++;
        end
    endtask

    int           cyc;
    bit           busySeen;
    logic [N-1:0] midQ;
    int           pulses;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] expQ;
    logic [N-1:0] expR;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset q", 32'(quotient), 32'd0);
        checkOutput("reset r", 32'(remainder), 32'd0);
        checkOutput("reset dz", 32'(divZero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 100 / 7
        applyStimulus(16'd100, 16'd7, 1'b0, cyc, busySeen, midQ);
        checkOutput("t1 latency", 32'(cyc), 32'd17);
        checkOutput("t1 q", 32'(quotient), 32'd14);
        checkOutput("t1 r", 32'(remainder), 32'd2);
        checkOutput("t1 dz", 32'(divZero), 32'd0);
        checkOutput("t1 busy seen", 32'(busySeen), 32'd1);
        stepCycles(3, pulses);
        checkOutput("t1 single pulse", 32'(pulses), 32'd0);
        checkOutput("t1 q held", 32'(quotient), 32'd14);

        // Extremes
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, cyc, busySeen, midQ);
        checkOutput("t2a q", 32'(quotient), 32'hFFFF);
        checkOutput("t2a r", 32'(remainder), 32'd0);
        stepCycles(1, pulses);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, cyc, busySeen, midQ);
        checkOutput("t2b q", 32'(quotient), 32'd1);
        checkOutput("t2b r", 32'(remainder), 32'd0);
        stepCycles(1, pulses);

        // Divide by zero
        applyStimulus(16'd5, 16'd0, 1'b0, cyc, busySeen, midQ);
        checkOutput("t3 latency", 32'(cyc), 32'd1);
        checkOutput("t3 q", 32'(quotient), 32'hFFFF);
        checkOutput("t3 r", 32'(remainder), 32'd5);
        checkOutput("t3 dz", 32'(divZero), 32'd1);
        checkOutput("t3 busy never", 32'(busySeen), 32'd0);
        stepCycles(2, pulses);
        checkOutput("t3 dz held", 32'(divZero), 32'd1);

        // Dividend < divisor, with a start pulse that must be ignored
        applyStimulus(16'd3, 16'd10, 1'b1, cyc, busySeen, midQ);
        checkOutput("t4 latency", 32'(cyc), 32'd17);
        checkOutput("t4 q", 32'(quotient), 32'd0);
        checkOutput("t4 r", 32'(remainder), 32'd3);
        checkOutput("t4 dz", 32'(divZero), 32'd0);
        stepCycles(20, pulses);
        checkOutput("t4 no extra done", 32'(pulses), 32'd0);

        // Back-to-back: second start issued in the done cycle of the first
        applyStimulus(16'd20, 16'd6, 1'b0, cyc, busySeen, midQ);
        checkOutput("t5a q", 32'(quotient), 32'd3);
        checkOutput("t5a r", 32'(remainder), 32'd2);
        applyStimulus(16'd50, 16'd5, 1'b0, cyc, busySeen, midQ);
        checkOutput("t5 latency", 32'(cyc), 32'd17);
        checkOutput("t5 held mid", 32'(midQ), 32'd3);
        checkOutput("t5 q", 32'(quotient), 32'd10);
        checkOutput("t5 r", 32'(remainder), 32'd0);
        stepCycles(1, pulses);

        // Asynchronous reset in the middle of a calculation
        start    = 1'b1;
        dividend = 16'd60000;
        divisor  = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6 rst busy", 32'(busy), 32'd0);
        checkOutput("t6 rst q", 32'(quotient), 32'd0);
        checkOutput("t6 rst r", 32'(remainder), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stepCycles(20, pulses);
        checkOutput("t6 no done", 32'(pulses), 32'd0);
        applyStimulus(16'd1000, 16'd33, 1'b0, cyc, busySeen, midQ);
        checkOutput("t6 latency", 32'(cyc), 32'd17);
        checkOutput("t6 q", 32'(quotient), 32'd30);
        checkOutput("t6 r", 32'(remainder), 32'd10);
        stepCycles(1, pulses);

        // Random pairs against a behavioural reference
        for (int k = 0; k < 300; k++) begin
            ra = 16'($urandom);
            rb = (k % 17 == 0) ? 16'd0 : 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            if (rb == 16'd0) begin
                expQ = 16'hFFFF;
                expR = ra;
            end else begin
                expQ = ra / rb;
                expR = ra % rb;
            end
            applyStimulus(ra, rb, 1'b0, cyc, busySeen, midQ);
            checkOutput("rand latency", 32'(cyc), (rb == 16'd0) ? 32'd1 : 32'd17);
            checkOutput("rand q", 32'(quotient), 32'(expQ));
            checkOutput("rand r", 32'(remainder), 32'(expR));
            checkOutput("rand dz", 32'(divZero), (rb == 16'd0) ? 32'd1 : 32'd0);
            stepCycles(1, pulses);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
